// File: rtl/ccff_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : ccff_cfg_loader
// Purpose  : Configuration-chain loader for the eFPGA fabric. Accepts
//            bitstream words over a valid/ready handshake and serialises
//            them LSB-first into the configuration flip-flop chain. Reports
//            completion, abort and the XOR signature of the bits that leave
//            the chain tail while the load runs.
//
// Ports
//   i_prog_clk       programming clock, all state on the rising edge
//   i_pReset         synchronous active-high reset
//   i_start          one-cycle pulse, begins a load from IDLE/DONE/ABORTED
//   i_abort          terminates a load in progress (wins over i_start)
//   i_word_valid     bitstream word available
//   i_word_data      bitstream word, bit 0 shifted first
//   o_word_ready     loader accepts a word this cycle
//   o_ccff_head      serial data into the chain (0 when not shifting)
//   o_ccff_shift_en  chain advances at the next i_prog_clk edge
//   i_ccff_tail      serial data leaving the chain
//   o_busy           load in progress (WAIT_WORD or SHIFT)
//   o_done           last load completed with CHAIN_LEN bits shifted
//   o_error          last load was aborted
//   o_bit_count      bits shifted in the current/last load
//   o_tail_parity    XOR of i_ccff_tail over the shift cycles of the load
//
// Revision : 1.0 - initial release
// ============================================================================
module ccff_cfg_loader #(
    parameter int CHAIN_LEN = 1024,
    parameter int WORD_W    = 32
) (
    input  logic                             i_prog_clk,
    input  logic                             i_pReset,
    input  logic                             i_start,
    input  logic                             i_abort,
    input  logic                             i_word_valid,
    input  logic [WORD_W-1:0]                i_word_data,
    output logic                             o_word_ready,
    output logic                             o_ccff_head,
    output logic                             o_ccff_shift_en,
    input  logic                             i_ccff_tail,
    output logic                             o_busy,
    output logic                             o_done,
    output logic                             o_error,
    output logic [$clog2(CHAIN_LEN+1)-1:0]   o_bit_count,
    output logic                             o_tail_parity
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int IDX_W = $clog2(WORD_W);

    // Shift-cycle comparisons are made against the pre-increment values, so
    // the terminal values are one below the counts they stand for.
    localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(WORD_W - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_WORD = 3'd1,
        S_SHIFT     = 3'd2,
        S_DONE      = 3'd3,
        S_ABORTED   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [WORD_W-1:0]   r_shreg;
    logic [IDX_W-1:0]    r_index;
    logic [CNT_W-1:0]    r_bit_count;
    logic                r_tail_parity;

    logic                w_word_ready;
    logic                w_load;
    logic                w_shift;
    logic                w_clear;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge i_prog_clk) begin
        if (i_pReset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_word_ready = 1'b0;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_clear      = 1'b0;

        case (r_state)
            S_IDLE, S_DONE, S_ABORTED: begin
                // i_abort is meaningless outside a load and is ignored here.
                if (i_start) begin
                    w_next_state = S_WAIT_WORD;
                    w_clear      = 1'b1;
                end
            end

            S_WAIT_WORD: begin
                // Ready is withheld during an abort cycle so that no word is
                // consumed by a load that is being torn down.
                if (i_abort) begin
                    w_next_state = S_ABORTED;
                end else begin
                    w_word_ready = 1'b1;
                    if (i_word_valid) begin
                        w_load       = 1'b1;
                        w_next_state = S_SHIFT;
                    end
                end
            end

            S_SHIFT: begin
                // An abort suppresses the shift of this cycle entirely.
                if (i_abort) begin
                    w_next_state = S_ABORTED;
                end else begin
                    w_shift = 1'b1;
                    // Chain-full takes precedence: leftover bits of the final
                    // word are simply dropped.
                    if (r_bit_count == C_LAST_BIT) begin
                        w_next_state = S_DONE;
                    end else if (r_index == C_LAST_IDX) begin
                        w_next_state = S_WAIT_WORD;
                    end
                end
            end

            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: word shift register, bit index, load counter, tail signature
    // ------------------------------------------------------------------------
    always_ff @(posedge i_prog_clk) begin
        if (i_pReset) begin
            r_shreg       <= '0;
            r_index       <= '0;
            r_bit_count   <= '0;
            r_tail_parity <= 1'b0;
        end else begin
            if (w_clear) begin
                r_bit_count   <= '0;
                r_tail_parity <= 1'b0;
            end

            if (w_load) begin
                r_shreg <= i_word_data;
                r_index <= '0;
            end else if (w_shift) begin
                // Shift right so the bit at the current index is always at
                // position 0; the index only tracks word progress.
                r_shreg       <= {1'b0, r_shreg[WORD_W-1:1]};
                r_index       <= r_index + IDX_W'(1);
                r_bit_count   <= r_bit_count + CNT_W'(1);
                r_tail_parity <= r_tail_parity ^ i_ccff_tail;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign o_word_ready    = w_word_ready;
    assign o_ccff_shift_en = w_shift;
    assign o_ccff_head     = w_shift & r_shreg[0];
    assign o_busy          = (r_state == S_WAIT_WORD) || (r_state == S_SHIFT);
    // Reset is the only way back to IDLE, so the flags can follow the state.
    assign o_done          = (r_state == S_DONE);
    assign o_error         = (r_state == S_ABORTED);
    assign o_bit_count     = r_bit_count;
    assign o_tail_parity   = r_tail_parity;

endmodule
`default_nettype wire

// File: tb/tb_ccff_cfg_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ccff_cfg_loader
// Purpose  : Scoreboard bench for ccff_cfg_loader with a behavioural model of
//            the configuration chain. Stimulus pushes expected head bits and
//            end-of-load records; a negedge monitor pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ccff_cfg_loader;

    localparam int CHAIN_LEN = 40;
    localparam int WORD_W    = 32;
    localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
    localparam int MAX_WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;

    logic              clk = 1'b0;
    logic              i_pReset;
    logic              i_start;
    logic              i_abort;
    logic              i_word_valid;
    logic [WORD_W-1:0] i_word_data;
    logic              o_word_ready;
    logic              o_ccff_head;
    logic              o_ccff_shift_en;
    logic              i_ccff_tail;
    logic              o_busy;
    logic              o_done;
    logic              o_error;
    logic [CNT_W-1:0]  o_bit_count;
    logic              o_tail_parity;

    always #5 clk = ~clk;

    ccff_cfg_loader #(
        .CHAIN_LEN (CHAIN_LEN),
        .WORD_W    (WORD_W)
    ) dut (
        .i_prog_clk      (clk),
        .i_pReset        (i_pReset),
        .i_start         (i_start),
        .i_abort         (i_abort),
        .i_word_valid    (i_word_valid),
        .i_word_data     (i_word_data),
        .o_word_ready    (o_word_ready),
        .o_ccff_head     (o_ccff_head),
        .o_ccff_shift_en (o_ccff_shift_en),
        .i_ccff_tail     (i_ccff_tail),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_error         (o_error),
        .o_bit_count     (o_bit_count),
        .o_tail_parity   (o_tail_parity)
    );

    // ---------------- configuration chain model ----------------
    logic [CHAIN_LEN-1:0] chain      = '0;
    logic [CHAIN_LEN-1:0] chain_init = '0;
    logic                 chain_load = 1'b0;

    always @(posedge clk) begin
        if (chain_load)           chain <= chain_init;
        else if (o_ccff_shift_en) chain <= {chain[CHAIN_LEN-2:0], o_ccff_head};
    end
    assign i_ccff_tail = chain[CHAIN_LEN-1];

    // ---------------- scoreboard ----------------
    typedef struct {
        logic done;
        logic err;
        int   cnt;
        logic par;
    } end_t;

    logic  q_head[$];
    end_t  q_end[$];
    int    n_vec = 0;
    int    n_err = 0;
    logic  mon_en = 1'b0;
    logic  prev_fin = 1'b0;
    logic [WORD_W-1:0] stim_w [MAX_WORDS];

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        logic exp_b;
        logic fin;
        end_t e;
        if (mon_en) begin
            if (o_ccff_shift_en) begin
                if (q_head.size() == 0) begin
                    check("unexpected_shift", 1, 0);
                end else begin
                    exp_b = q_head.pop_front();
                    check("ccff_head", {63'd0, o_ccff_head}, {63'd0, exp_b});
                end
                check("ready_low_in_shift", {63'd0, o_word_ready}, 0);
            end else begin
                check("head_zero_idle", {63'd0, o_ccff_head}, 0);
            end
            fin = o_done | o_error;
            if (fin && !prev_fin) begin
                if (q_end.size() == 0) begin
                    check("unexpected_end", 1, 0);
                end else begin
                    e = q_end.pop_front();
                    check("end_done",   {63'd0, o_done},        {63'd0, e.done});
                    check("end_error",  {63'd0, o_error},       {63'd0, e.err});
                    check("end_count",  64'(o_bit_count),       64'(e.cnt));
                    check("end_parity", {63'd0, o_tail_parity}, {63'd0, e.par});
                    check("end_busy",   {63'd0, o_busy},        0);
                end
            end
            prev_fin = fin;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [CHAIN_LEN-1:0] v);
        chain_init = v;
        chain_load = 1'b1;
        tick();
        chain_load = 1'b0;
    endtask

    task automatic do_abort(input int shifted, input logic with_start);
        i_abort = 1'b1;
        i_start = with_start;
        #1;
        check("abort_no_shift", {63'd0, o_ccff_shift_en}, 0);
        tick();
        i_abort = 1'b0;
        i_start = 1'b0;
        check("abort_error", {63'd0, o_error}, 1);
        check("abort_busy",  {63'd0, o_busy},  0);
        check("abort_count", 64'(o_bit_count), 64'(shifted));
        q_head.delete();
    endtask

    // One load using stim_w. abort_at: number of completed shifts at which
    // abort is raised (-1: never). glitch_at: shift position at which a stray
    // start is raised.
    task automatic run_load(input int stall, input int abort_at,
                            input int glitch_at, input logic start_with_abort);
        logic [CHAIN_LEN-1:0] snap;
        int   k, shifted, w, nb;
        logic p;
        logic stop;
        end_t e;

        // Every bit leaving the tail during a load of <= CHAIN_LEN shifts is
        // pre-load chain content, taken from the tail end first.
        snap = chain;
        k = (abort_at >= 0) ? abort_at : CHAIN_LEN;
        p = 1'b0;
        for (int j = 0; j < k; j++) p ^= snap[CHAIN_LEN-1-j];
        e.done = (k == CHAIN_LEN);
        e.err  = (k != CHAIN_LEN);
        e.cnt  = k;
        e.par  = p;
        q_end.push_back(e);

        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("ready_after_start", {63'd0, o_word_ready}, 1);
        check("error_cleared",     {63'd0, o_error},      0);
        check("count_cleared",     64'(o_bit_count),      0);

        shifted = 0;
        w       = 0;
        stop    = 1'b0;
        while (!stop && shifted < CHAIN_LEN) begin
            for (int s = 0; s < stall; s++) begin
                i_word_valid = 1'b0;
                i_word_data  = $urandom;
                check("stall_no_shift", {63'd0, o_ccff_shift_en}, 0);
                check("stall_count",    64'(o_bit_count), 64'(shifted));
                tick();
            end
            if (abort_at == shifted) begin
                do_abort(shifted, start_with_abort);
                stop = 1'b1;
            end else begin
                nb = (CHAIN_LEN - shifted < WORD_W) ? CHAIN_LEN - shifted : WORD_W;
                for (int j = 0; j < nb; j++) q_head.push_back(stim_w[w][j]);
                i_word_valid = 1'b1;
                i_word_data  = stim_w[w];
                check("ready_in_wait", {63'd0, o_word_ready}, 1);
                tick();
                i_word_valid = 1'b0;
                i_word_data  = $urandom;
                for (int j = 0; j < nb && !stop; j++) begin
                    if (abort_at == shifted) begin
                        do_abort(shifted, start_with_abort);
                        stop = 1'b1;
                    end else begin
                        if (glitch_at == shifted) i_start = 1'b1;
                        tick();
                        i_start = 1'b0;
                        shifted++;
                    end
                end
                w++;
            end
        end
        if (!stop) begin
            check("done_flag",   {63'd0, o_done}, 1);
            check("final_count", 64'(o_bit_count), CHAIN_LEN);
            check("done_busy",   {63'd0, o_busy}, 0);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [CHAIN_LEN-1:0] v;
        logic [63:0]          stream;
        int                   ab;

        i_pReset     = 1'b1;
        i_start      = 1'b0;
        i_abort      = 1'b0;
        i_word_valid = 1'b0;
        i_word_data  = '0;
        tick();
        tick();
        check("rst_ready",  {63'd0, o_word_ready},    0);
        check("rst_shift",  {63'd0, o_ccff_shift_en}, 0);
        check("rst_head",   {63'd0, o_ccff_head},     0);
        check("rst_busy",   {63'd0, o_busy},          0);
        check("rst_done",   {63'd0, o_done},          0);
        check("rst_error",  {63'd0, o_error},         0);
        check("rst_parity", {63'd0, o_tail_parity},   0);
        check("rst_count",  64'(o_bit_count),         0);
        i_pReset = 1'b0;
        tick();
        check("idle_ready", {63'd0, o_word_ready}, 0);
        mon_en = 1'b1;

        // Directed load with odd-weight chain contents.
        v = {8'h5A, 32'h1234_5670};
        if (($countones(v) % 2) == 0) v[0] = ~v[0];
        preload(v);
        stim_w[0] = 32'hA5A5_0F0F;
        stim_w[1] = 32'h0000_00C3;
        run_load(0, -1, -1, 1'b0);
        check("parity_odd_preload", {63'd0, o_tail_parity}, 1);

        // All-zero load displaces the first bitstream.
        stream    = {32'h0000_00C3, 32'hA5A5_0F0F};
        stim_w[0] = '0;
        stim_w[1] = '0;
        run_load(0, -1, -1, 1'b0);
        check("parity_second_load", {63'd0, o_tail_parity},
              64'($countones(stream[CHAIN_LEN-1:0]) % 2));

        // Stall of 10 cycles before each word.
        stim_w[0] = $urandom;
        stim_w[1] = $urandom;
        run_load(10, -1, -1, 1'b0);

        // Abort on the 5th shift of the first word, then a clean reload.
        run_load(0, 4, -1, 1'b0);
        run_load(0, -1, -1, 1'b0);

        // Stray start during SHIFT, then start+abort in the same cycle.
        run_load(0, -1, 10, 1'b0);
        run_load(0, 20, -1, 1'b1);
        // Abort while waiting for the second word.
        run_load(2, 32, -1, 1'b0);

        // Randomized loads.
        for (int n = 0; n < 20; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                v = {$urandom, $urandom};
                preload(v);
            end
            for (int i = 0; i < MAX_WORDS; i++) stim_w[i] = $urandom;
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, CHAIN_LEN-1)) : -1;
            run_load(int'($urandom_range(0, 3)), ab, -1, 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a load: four shift cycles reach the chain,
        // the fourth being the reset cycle itself.
        stim_w[0] = $urandom;
        i_start   = 1'b1;
        tick();
        i_start   = 1'b0;
        for (int j = 0; j < 4; j++) q_head.push_back(stim_w[0][j]);
        i_word_valid = 1'b1;
        i_word_data  = stim_w[0];
        tick();
        i_word_valid = 1'b0;
        repeat (3) tick();
        i_pReset = 1'b1;
        tick();
        i_pReset = 1'b0;
        check("midrst_busy",  {63'd0, o_busy},       0);
        check("midrst_error", {63'd0, o_error},      0);
        check("midrst_ready", {63'd0, o_word_ready}, 0);
        check("midrst_count", 64'(o_bit_count),      0);
        repeat (3) tick();

        check("head_queue_drained", 64'(q_head.size()), 0);
        check("end_queue_drained",  64'(q_end.size()),  0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
